// File: rtl/morra_match_sequencer_if.sv
// Signal bundle between the tournament sequencer, the two player
// front-ends and the MorraCinese game core.
interface morra_match_sequencer_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_rounds;
    logic       p1_valid;
    logic       p1_ready;
    logic [1:0] p1_move;
    logic       p2_valid;
    logic       p2_ready;
    logic [1:0] p2_move;
    logic       core_inizia;
    logic [1:0] core_primo;
    logic [1:0] core_secondo;
    logic [1:0] core_manche;
    logic [1:0] core_partita;
    logic       res_valid;
    logic [1:0] res_manche;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       tourn_done;
    logic [1:0] tourn_winner;

    modport slave (
        input  cfg_valid, cfg_rounds,
        input  p1_valid, p1_move, p2_valid, p2_move,
        input  core_manche, core_partita,
        output cfg_ready, p1_ready, p2_ready,
        output core_inizia, core_primo, core_secondo,
        output res_valid, res_manche,
        output score_p1, score_p2, tourn_done, tourn_winner
    );

    modport master (
        output cfg_valid, cfg_rounds,
        output p1_valid, p1_move, p2_valid, p2_move,
        output core_manche, core_partita,
        input  cfg_ready, p1_ready, p2_ready,
        input  core_inizia, core_primo, core_secondo,
        input  res_valid, res_manche,
        input  score_p1, score_p2, tourn_done, tourn_winner
    );
endinterface

// File: rtl/morra_match_sequencer.sv
// Multi-game tournament sequencer for the MorraCinese core: collects moves,
// drives one manche per cycle pulse, and tracks game scores.
module morra_match_sequencer #(
    parameter int NUM_GAMES    = 3,
    parameter int MOVE_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    morra_match_sequencer_if.slave bus
);
    localparam int TW = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_COLLECT, S_ISSUE, S_WAIT, S_GAME_END, S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cfg_q, cfg_d;
    logic [1:0]    buf1_q, buf1_d, buf2_q, buf2_d;
    logic          full1_q, full1_d, full2_q, full2_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]    games_q, games_d;
    logic [3:0]    sc1_q, sc1_d, sc2_q, sc2_d;
    logic [1:0]    part_q, part_d;
    logic [1:0]    res_m_q, res_m_d;
    logic          res_v_q, res_v_d;
    logic          cfg_rdy_q, cfg_rdy_d;

    logic          p1_rdy, p2_rdy, inizia;
    logic [1:0]    primo, secondo;
    logic          tmo_hit;

    assign tmo_hit = (MOVE_TIMEOUT != 0) && (tmo_q == TW'(MOVE_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cfg_q     <= 4'd0;
            buf1_q    <= 2'b00;
            buf2_q    <= 2'b00;
            full1_q   <= 1'b0;
            full2_q   <= 1'b0;
            tmo_q     <= '0;
            games_q   <= 4'd0;
            sc1_q     <= 4'd0;
            sc2_q     <= 4'd0;
            part_q    <= 2'b00;
            res_m_q   <= 2'b00;
            res_v_q   <= 1'b0;
            cfg_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            buf1_q    <= buf1_d;
            buf2_q    <= buf2_d;
            full1_q   <= full1_d;
            full2_q   <= full2_d;
            tmo_q     <= tmo_d;
            games_q   <= games_d;
            sc1_q     <= sc1_d;
            sc2_q     <= sc2_d;
            part_q    <= part_d;
            res_m_q   <= res_m_d;
            res_v_q   <= res_v_d;
            cfg_rdy_q <= cfg_rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        buf1_d  = buf1_q;
        buf2_d  = buf2_q;
        full1_d = full1_q;
        full2_d = full2_q;
        tmo_d   = tmo_q;
        games_d = games_q;
        sc1_d   = sc1_q;
        sc2_d   = sc2_q;
        part_d  = part_q;
        res_m_d = res_m_q;
        res_v_d = 1'b0;
        p1_rdy  = 1'b0;
        p2_rdy  = 1'b0;
        inizia  = 1'b0;
        primo   = 2'b00;
        secondo = 2'b00;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.cfg_valid && cfg_rdy_q) begin
                    cfg_d   = bus.cfg_rounds;
                    sc1_d   = 4'd0;
                    sc2_d   = 4'd0;
                    games_d = 4'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                inizia  = 1'b1;
                primo   = cfg_q[3:2];
                secondo = cfg_q[1:0];
                tmo_d   = '0;
                state_d = S_COLLECT;
            end
            S_COLLECT: begin
                p1_rdy = ~full1_q;
                p2_rdy = ~full2_q;
                if (bus.p1_valid && !full1_q) begin
                    buf1_d  = bus.p1_move;
                    full1_d = 1'b1;
                end
                if (bus.p2_valid && !full2_q) begin
                    buf2_d  = bus.p2_move;
                    full2_d = 1'b1;
                end
                tmo_d = tmo_q + TW'(1);
                if (full1_d && full2_d) begin
                    state_d = S_ISSUE;
                end else if (tmo_hit) begin
                    // A stalled player forfeits the manche with an illegal move
                    if (!full1_d) buf1_d = 2'b00;
                    if (!full2_d) buf2_d = 2'b00;
                    full1_d = 1'b1;
                    full2_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                primo   = buf1_q;
                secondo = buf2_q;
                buf1_d  = 2'b00;
                buf2_d  = 2'b00;
                full1_d = 1'b0;
                full2_d = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                res_v_d = 1'b1;
                res_m_d = bus.core_manche;
                part_d  = bus.core_partita;
                tmo_d   = '0;
                if (bus.core_partita == 2'b00) state_d = S_COLLECT;
                else                           state_d = S_GAME_END;
            end
            S_GAME_END: begin
                if (part_q == 2'b01 && sc1_q != 4'hF) sc1_d = sc1_q + 4'd1;
                if (part_q == 2'b10 && sc2_q != 4'hF) sc2_d = sc2_q + 4'd1;
                games_d = games_q + 4'd1;
                if (games_d == 4'(NUM_GAMES)) state_d = S_DONE;
                else                          state_d = S_START;
            end
            default: state_d = S_IDLE;
        endcase

        cfg_rdy_d = (state_d == S_IDLE) || (state_d == S_DONE);
    end

    assign bus.cfg_ready    = cfg_rdy_q;
    assign bus.p1_ready     = p1_rdy;
    assign bus.p2_ready     = p2_rdy;
    assign bus.core_inizia  = inizia;
    assign bus.core_primo   = primo;
    assign bus.core_secondo = secondo;
    assign bus.res_valid    = res_v_q;
    assign bus.res_manche   = res_m_q;
    assign bus.score_p1     = sc1_q;
    assign bus.score_p2     = sc2_q;
    assign bus.tourn_done   = (state_q == S_DONE);
    assign bus.tourn_winner = (state_q != S_DONE) ? 2'b00 :
                              (sc1_q > sc2_q)     ? 2'b01 :
                              (sc1_q < sc2_q)     ? 2'b10 : 2'b11;
endmodule
